// File: rtl/button_conditioner_pkg.sv
// Shared defaults and helpers for the push-button conditioning block.
package button_conditioner_pkg;

    localparam int unsigned NUM_BTN_DEF         = 4;
    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;

    // Debounced (accepted) state of one button.
    typedef enum logic {
        BTN_RELEASED = 1'b0,
        BTN_PRESSED  = 1'b1
    } btn_state_e;

    // Mismatch counter width: ceil(log2(cycles)), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce.sv
// Single-button conditioner: synchronizer, mismatch counter, debounced state,
// press/release strobes and press toggle. Raw input is active-low.
module btn_debounce
    import button_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw_key_i,
    output logic level_o,
    output logic toggle_o,
    output logic press_o,
    output logic release_o
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q,     cnt_d;
    btn_state_e             state_q,   state_d;
    logic                   toggle_q,  toggle_d;
    logic                   press_q,   press_d;
    logic                   release_q, release_d;

    logic       pressed_sync;
    btn_state_e sync_state;

    assign pressed_sync = ~sync_q[SYNC_STAGES-1];
    assign sync_state   = btn_state_e'(pressed_sync);

    // Synchronizer chain; resets to the released (high) raw level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_key_i};
        end
    end

    // Debounce state, counter and strobe registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= BTN_RELEASED;
            cnt_q     <= '0;
            toggle_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            toggle_q  <= toggle_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Count consecutive mismatch cycles; accept the new level on the last one.
    // Strobes are registered alongside the state so they coincide with the
    // first cycle the new debounced level is visible.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        toggle_d  = toggle_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (sync_state != state_q) begin
            if (cnt_q == CNT_LAST) begin
                state_d   = sync_state;
                press_d   = pressed_sync;
                release_d = ~pressed_sync;
                if (pressed_sync) begin
                    toggle_d = ~toggle_q;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign level_o   = (state_q == BTN_PRESSED);
    assign toggle_o  = toggle_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions NUM_BTN active-low push-buttons and packs the PIO export word:
// low half = debounced pressed level, high half = per-button press toggle.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned NUM_BTN         = NUM_BTN_DEF,
    parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_BTN-1:0]   raw_keys,
    output logic [2*NUM_BTN-1:0] buttons_export,
    output logic [NUM_BTN-1:0]   press_pulse,
    output logic [NUM_BTN-1:0]   release_pulse
);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] toggle;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_btn (
            .clk       (clk),
            .rstn      (rstn),
            .raw_key_i (raw_keys[g]),
            .level_o   (level[g]),
            .toggle_o  (toggle[g]),
            .press_o   (press_pulse[g]),
            .release_o (release_pulse[g])
        );
    end

    assign buttons_export = {toggle, level};

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce (4 cycles).
module tb_button_conditioner;

    logic       clk;
    logic       rstn;
    logic [3:0] raw_keys;
    logic [7:0] buttons_export;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;

    int passed = 0;
    int total  = 0;
    int press_cnt;
    int rel_cnt;

    button_conditioner #(
        .NUM_BTN         (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .raw_keys       (raw_keys),
        .buttons_export (buttons_export),
        .press_pulse    (press_pulse),
        .release_pulse  (release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] exp_exp,
                           input logic [3:0] exp_press, input logic [3:0] exp_rel);
        chk({tag, ".export"},  buttons_export,        exp_exp);
        chk({tag, ".press"},   {4'h0, press_pulse},   {4'h0, exp_press});
        chk({tag, ".release"}, {4'h0, release_pulse}, {4'h0, exp_rel});
    endtask

    initial begin
        rstn     = 1'b0;
        raw_keys = 4'hF;
        step(3);
        chk_all("reset", 8'h00, 4'h0, 4'h0);
        rstn = 1'b1;

        // Idle, all released for 100 cycles.
        for (int k = 0; k < 100; k++) begin
            step(1);
            chk_all("idle", 8'h00, 4'h0, 4'h0);
        end

        // Button 0 press: visible on the 6th rising edge after the change.
        raw_keys = 4'hE;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (k < 6)       chk_all("press0_wait", 8'h00, 4'h0, 4'h0);
            else if (k == 6) chk_all("press0_hit",  8'h11, 4'h1, 4'h0);
            else             chk_all("press0_hold", 8'h11, 4'h0, 4'h0);
        end

        // Button 1 glitch of 3 cycles: longest rejected glitch.
        raw_keys = 4'hC;
        step(3);
        raw_keys = 4'hE;
        for (int k = 0; k < 12; k++) begin
            step(1);
            chk_all("glitch1", 8'h11, 4'h0, 4'h0);
        end

        // Button 2 press / release / press, 10 cycles each.
        press_cnt = 0;
        rel_cnt   = 0;
        raw_keys  = 4'hA;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (press_pulse[2])   press_cnt++;
            if (release_pulse[2]) rel_cnt++;
            if (k == 6) chk_all("press2a", 8'h55, 4'h4, 4'h0);
        end
        raw_keys = 4'hE;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (press_pulse[2])   press_cnt++;
            if (release_pulse[2]) rel_cnt++;
            if (k == 6) chk_all("release2", 8'h51, 4'h0, 4'h4);
        end
        raw_keys = 4'hA;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (press_pulse[2])   press_cnt++;
            if (release_pulse[2]) rel_cnt++;
            if (k == 6) chk_all("press2b", 8'h15, 4'h4, 4'h0);
        end
        chk("press2_count",   8'(press_cnt), 8'd2);
        chk("release2_count", 8'(rel_cnt),   8'd1);

        // Release everything: simultaneous release strobes on buttons 0 and 2.
        raw_keys = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (k == 6) chk_all("release_all", 8'h10, 4'h0, 4'h5);
        end

        // Reset clears toggles.
        rstn = 1'b0;
        #1;
        chk_all("reset2", 8'h00, 4'h0, 4'h0);
        step(2);
        rstn = 1'b1;
        step(3);
        chk_all("post_reset2", 8'h00, 4'h0, 4'h0);

        // All four pressed in one cycle.
        raw_keys = 4'h0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (k < 6)       chk_all("all_wait", 8'h00, 4'h0, 4'h0);
            else if (k == 6) chk_all("all_hit",  8'hFF, 4'hF, 4'h0);
            else             chk_all("all_hold", 8'hFF, 4'h0, 4'h0);
        end

        // Clean up, then reset mid-debounce of button 3.
        raw_keys = 4'hF;
        step(8);
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
        step(3);
        chk_all("pre_mid", 8'h00, 4'h0, 4'h0);
        raw_keys = 4'h7;
        step(4);
        chk_all("mid_count2", 8'h00, 4'h0, 4'h0);
        rstn = 1'b0;
        #1;
        chk_all("mid_reset", 8'h00, 4'h0, 4'h0);
        step(2);
        chk_all("mid_reset_hold", 8'h00, 4'h0, 4'h0);
        rstn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            if (k < 6)       chk_all("held_wait", 8'h00, 4'h0, 4'h0);
            else if (k == 6) chk_all("held_hit",  8'h88, 4'h8, 4'h0);
            else             chk_all("held_hold", 8'h88, 4'h0, 4'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter NUM_BTN, default 4: number of push-buttons conditioned.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth, legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 500000: stable-mismatch cycles required to accept a change (10 ms at 50 MHz), legal minimum 2.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 raw_keys  input  NUM_BTN  board push-buttons, active-low, asynchronous to clk.
REQ-007 buttons_export  output  2*NUM_BTN  value presented to the PCIe system's buttons PIO input: [NUM_BTN-1:0] debounced pressed level (1 = pressed), [2*NUM_BTN-1:NUM_BTN] per-button press toggle bits.
REQ-008 press_pulse  output  NUM_BTN  one-cycle strobe per accepted press.
REQ-009 release_pulse  output  NUM_BTN  one-cycle strobe per accepted release.

Function
REQ-010 Each raw_keys bit SHALL pass through SYNC_STAGES flops before any other use.
REQ-011 Each button SHALL hold a stable state (pressed/released) and a counter of width ceil(log2(DEBOUNCE_CYCLES)).
REQ-012 The counter SHALL increment on each cycle in which the synchronized level differs from the stable state, and SHALL clear on any cycle in which they agree.
REQ-013 When the counter equals DEBOUNCE_CYCLES-1 and a mismatch persists, the stable state SHALL flip on that edge and the counter SHALL clear.
REQ-014 Latency from a clean raw edge to the debounced level changing SHALL be exactly SYNC_STAGES + DEBOUNCE_CYCLES cycles.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no change on any output.
REQ-016 press_pulse[i] SHALL assert for exactly one cycle, coincident with the first cycle the debounced level of button i reads pressed.
REQ-017 release_pulse[i] SHALL likewise assert for one cycle on the first released cycle.
REQ-018 Toggle bit i SHALL invert in the same cycle press_pulse[i] asserts, and never on release.
REQ-019 Buttons SHALL be fully independent; simultaneous presses on several buttons SHALL produce simultaneous, independent pulses and toggles.
REQ-020 The counter SHALL never wrap; it saturates by construction per REQ-013.
REQ-021 All outputs SHALL be registered; no combinational path from raw_keys to any output.

Reset
REQ-022 On rstn low, synchronizer flops SHALL reset to 1 (released raw level), so that no spurious press is generated after reset.
REQ-023 On rstn low, stable states, counters, toggle bits, press_pulse and release_pulse SHALL reset to 0; buttons_export SHALL read 0.
REQ-024 Reset asserted mid-debounce SHALL discard the partial count.
REQ-025 After rstn deasserts, a button held throughout reset SHALL be reported as a press after SYNC_STAGES + DEBOUNCE_CYCLES cycles.

Structure
REQ-026 A shared package SHALL hold the default constants (NUM_BTN, SYNC_STAGES, DEBOUNCE_CYCLES) and a function for counter width.
REQ-027 One sub-module, btn_debounce, SHALL implement the synchronizer, counter, stable state, pulse and toggle logic for a single button, instantiated NUM_BTN times via generate.
REQ-028 The top level SHALL only instantiate btn_debounce and pack buttons_export.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, NUM_BTN=4)
REQ-029 Reset release, raw_keys=4'hF held -> buttons_export=8'h00, no pulses for 100 cycles.
REQ-030 raw_keys[0] falls and is held -> press_pulse=4'h1 for one cycle, exactly 6 cycles after the sampled edge; buttons_export=8'h11 from that cycle.
REQ-031 raw_keys[1] low for 3 cycles then high -> no output change.
REQ-032 raw_keys[2]: press, release, press, each held for 10 cycles -> toggle bit 6 reads 1, then 0; two press_pulse[2] and one release_pulse[2] are seen.
REQ-033 raw_keys 4'hF to 4'h0 in one cycle -> press_pulse=4'hF in a single cycle; buttons_export=8'hFF.
REQ-034 rstn pulsed low at count 2 while button 3 is held -> all outputs 0; press reported 6 cycles after rstn rises.
